// File: rtl/pong_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_pkg                                                             |
// | Shared state encoding, winner codes and UART command bytes.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_RUNNING   = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic [7:0] CMD_START_DEF = 8'h53;
    localparam logic [7:0] CMD_RESET_DEF = 8'h52;

endpackage
`default_nettype wire

// File: rtl/pong_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_edge_detect                                                     |
// | Rising-edge pulse from a level using a registered previous sample.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pong_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= level;
        end
    end

    // A level held high yields one pulse on the cycle it first appears.
    assign pulse = level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/pong_game_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_game_ctl                                                        |
// | Pong game-flow FSM: serve delay, scoring, winner and UART commands.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pong_game_ctl
    import pong_pkg::*;
#(
    parameter int         CLKS_PER_SERVE = 12500000,
    parameter int         SCORE_LIMIT    = 9,
    parameter logic [7:0] CMD_START      = CMD_START_DEF,
    parameter logic [7:0] CMD_RESET      = CMD_RESET_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_dv_i,
    input  logic [7:0] rx_byte_i,
    input  logic       p1_miss_i,
    input  logic       p2_miss_i,
    output logic       game_active_o,
    output logic       ball_reset_o,
    output logic [3:0] p1_score_o,
    output logic [3:0] p2_score_o,
    output logic [1:0] winner_o,
    output logic [2:0] state_o
);

    localparam int               CNT_W    = $clog2(CLKS_PER_SERVE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_SERVE - 1);
    localparam logic [3:0]       LIMIT    = 4'(SCORE_LIMIT);

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [3:0]       r_p1, w_p1_next;
    logic [3:0]       r_p2, w_p2_next;
    logic [1:0]       r_winner, w_winner_next;
    logic             r_active, w_active_next;
    logic             r_ball_reset, w_ball_reset_next;
    logic             w_p1_edge, w_p2_edge;
    logic             w_start, w_clear;

    pong_edge_detect u_p1_edge (
        .clk   (clk_i),
        .rst   (rst_i),
        .level (p1_miss_i),
        .pulse (w_p1_edge)
    );

    pong_edge_detect u_p2_edge (
        .clk   (clk_i),
        .rst   (rst_i),
        .level (p2_miss_i),
        .pulse (w_p2_edge)
    );

    assign w_start = rx_dv_i && (rx_byte_i == CMD_START);
    assign w_clear = rx_dv_i && (rx_byte_i == CMD_RESET);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_p1_next         = r_p1;
        w_p2_next         = r_p2;
        w_winner_next     = r_winner;
        w_ball_reset_next = 1'b0;

        if (w_clear) begin
            w_state_next  = ST_IDLE;
            w_cnt_next    = '0;
            w_p1_next     = '0;
            w_p2_next     = '0;
            w_winner_next = WIN_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        w_ball_reset_next = 1'b1;
                        w_cnt_next        = '0;
                        w_state_next      = ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_RUNNING;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                ST_RUNNING: begin
                    // Simultaneous misses void the rally without scoring.
                    if (w_p1_edge || w_p2_edge) begin
                        w_state_next = ST_POINT;
                    end
                    if (w_p1_edge && !w_p2_edge && (r_p2 < LIMIT)) begin
                        w_p2_next = r_p2 + 4'd1;
                    end
                    if (w_p2_edge && !w_p1_edge && (r_p1 < LIMIT)) begin
                        w_p1_next = r_p1 + 4'd1;
                    end
                end
                ST_POINT: begin
                    if (r_p1 == LIMIT) begin
                        w_winner_next = WIN_P1;
                        w_state_next  = ST_GAME_OVER;
                    end else if (r_p2 == LIMIT) begin
                        w_winner_next = WIN_P2;
                        w_state_next  = ST_GAME_OVER;
                    end else begin
                        w_ball_reset_next = 1'b1;
                        w_cnt_next        = '0;
                        w_state_next      = ST_SERVE;
                    end
                end
                ST_GAME_OVER: begin
                    if (w_start) begin
                        w_p1_next         = '0;
                        w_p2_next         = '0;
                        w_winner_next     = WIN_NONE;
                        w_ball_reset_next = 1'b1;
                        w_cnt_next        = '0;
                        w_state_next      = ST_SERVE;
                    end
                end
                default: begin
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end
            endcase
        end

        // Registered from the next state so the enable drops with the miss edge.
        w_active_next = (w_state_next == ST_RUNNING);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt        <= '0;
            r_p1         <= '0;
            r_p2         <= '0;
            r_winner     <= WIN_NONE;
            r_active     <= 1'b0;
            r_ball_reset <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_p1         <= w_p1_next;
            r_p2         <= w_p2_next;
            r_winner     <= w_winner_next;
            r_active     <= w_active_next;
            r_ball_reset <= w_ball_reset_next;
        end
    end

    assign game_active_o = r_active;
    assign ball_reset_o  = r_ball_reset;
    assign p1_score_o    = r_p1;
    assign p2_score_o    = r_p2;
    assign winner_o      = r_winner;
    assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pong_game_ctl                                                     |
// | Expected output-change trace queued by stimulus, checked by monitor. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pong_game_ctl;
    import pong_pkg::*;

    localparam int N   = 8;
    localparam int LIM = 3;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       rx_dv   = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       p1_miss = 1'b0;
    logic       p2_miss = 1'b0;
    logic       game_active, ball_reset;
    logic [3:0] p1_score, p2_score;
    logic [1:0] winner;
    logic [2:0] state;

    pong_game_ctl #(
        .CLKS_PER_SERVE (N),
        .SCORE_LIMIT    (LIM),
        .CMD_START      (8'h53),
        .CMD_RESET      (8'h52)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rx_dv_i       (rx_dv),
        .rx_byte_i     (rx_byte),
        .p1_miss_i     (p1_miss),
        .p2_miss_i     (p2_miss),
        .game_active_o (game_active),
        .ball_reset_o  (ball_reset),
        .p1_score_o    (p1_score),
        .p2_score_o    (p2_score),
        .winner_o      (winner),
        .state_o       (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [14:0] snap;
    } exp_t;

    exp_t q[$];
    int   cyc       = 0;
    int   checks    = 0;
    int   failures  = 0;
    bit   mon_en    = 1'b0;
    bit   mon_first = 1'b1;
    bit   end_req   = 1'b0;
    bit   end_done  = 1'b0;
    logic [14:0] prev_snap;
    logic [14:0] cur_snap;
    exp_t        e;

    // Expected-model state
    logic [2:0] m_state = ST_IDLE;
    logic [3:0] m_p1    = 4'd0;
    logic [3:0] m_p2    = 4'd0;
    logic [1:0] m_win   = WIN_NONE;

    function automatic logic [14:0] mk(input logic [2:0] st, input logic act, input logic br,
                                       input logic [3:0] a, input logic [3:0] b, input logic [1:0] w);
        return {st, act, br, a, b, w};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every change in the output snapshot must match the queue head.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            cur_snap = mk(state, game_active, ball_reset, p1_score, p2_score, winner);
            if (mon_first || cur_snap !== prev_snap) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, cur_snap);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || cur_snap !== e.snap) begin
                        failures++;
                        $display("FAIL output_event got cyc=%0d snap=%h required cyc=%0d snap=%h",
                                 cyc, cur_snap, e.cyc, e.snap);
                    end
                end
            end
            prev_snap = cur_snap;
            mon_first = 1'b0;
        end
        if (end_req && !end_done) begin
            checks++;
            if (q.size() != 0) begin
                failures++;
                $display("FAIL pending_events got=%0d required=0", q.size());
            end
            end_done = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input logic [2:0] st, input logic act, input logic br);
        q.push_back('{c, mk(st, act, br, m_p1, m_p2, m_win)});
    endtask

    task automatic send(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick(1);
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    // START from IDLE or GAME_OVER; optionally a miss pulse during SERVE (ignored).
    task automatic start_game(input bit serve_miss);
        int c;
        c = cyc;
        if (m_state == ST_GAME_OVER) begin
            m_p1  = 4'd0;
            m_p2  = 4'd0;
            m_win = WIN_NONE;
        end
        push(c + 1, ST_SERVE, 1'b0, 1'b1);
        push(c + 2, ST_SERVE, 1'b0, 1'b0);
        push(c + 1 + N, ST_RUNNING, 1'b1, 1'b0);
        send(8'h53);
        if (serve_miss) begin
            p1_miss = 1'b1;
            tick(1);
            p1_miss = 1'b0;
            tick(N - 1);
        end else begin
            tick(N);
        end
        m_state = ST_RUNNING;
    endtask

    // Raise miss levels in RUNNING and hold them for 'hold' cycles.
    task automatic score_miss(input logic a, input logic b, input int hold, input bit wait_run);
        int c;
        c = cyc;
        if (a && !b && m_p2 < LIM) m_p2 = m_p2 + 4'd1;
        if (b && !a && m_p1 < LIM) m_p1 = m_p1 + 4'd1;
        push(c + 1, ST_POINT, 1'b0, 1'b0);
        if (m_p1 == LIM || m_p2 == LIM) begin
            m_win   = (m_p1 == LIM) ? WIN_P1 : WIN_P2;
            push(c + 2, ST_GAME_OVER, 1'b0, 1'b0);
            m_state = ST_GAME_OVER;
        end else begin
            push(c + 2, ST_SERVE, 1'b0, 1'b1);
            push(c + 3, ST_SERVE, 1'b0, 1'b0);
            if (wait_run) push(c + 2 + N, ST_RUNNING, 1'b1, 1'b0);
            m_state = wait_run ? ST_RUNNING : ST_SERVE;
        end
        p1_miss = a;
        p2_miss = b;
        tick(hold);
        p1_miss = 1'b0;
        p2_miss = 1'b0;
        if (m_state == ST_RUNNING && cyc < c + 2 + N) tick(c + 2 + N - cyc);
        else if (m_state == ST_SERVE && cyc < c + 4) tick(c + 4 - cyc);
        else tick(1);
    endtask

    task automatic clear_to_idle(input bit use_rst);
        int c;
        c       = cyc;
        m_p1    = 4'd0;
        m_p2    = 4'd0;
        m_win   = WIN_NONE;
        m_state = ST_IDLE;
        push(c + 1, ST_IDLE, 1'b0, 1'b0);
        if (use_rst) begin
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
        end else begin
            send(8'h52);
        end
        tick(1);
    endtask

    initial begin
        tick(3);
        push(cyc, ST_IDLE, 1'b0, 1'b0);
        mon_en = 1'b1;
        rst    = 1'b0;
        tick(2);

        send(8'h41);                      // unknown byte in IDLE
        tick(2);
        start_game(1'b0);                 // serve latency N+1
        score_miss(1'b1, 1'b0, 20, 1'b1); // held level scores once: 0:1
        send(8'h53);                      // START ignored in RUNNING
        tick(2);
        score_miss(1'b1, 1'b1, 2, 1'b1);  // simultaneous: no score
        score_miss(1'b0, 1'b1, 2, 1'b1);  // 1:1
        score_miss(1'b0, 1'b1, 2, 1'b0);  // 2:1, now mid-SERVE
        clear_to_idle(1'b0);              // CMD_RESET
        send(8'h41);
        tick(3);

        start_game(1'b0);
        score_miss(1'b0, 1'b1, 2, 1'b1);
        score_miss(1'b0, 1'b1, 2, 1'b1);
        score_miss(1'b0, 1'b1, 2, 1'b1);  // 3:0, P1 wins
        p2_miss = 1'b1; tick(2); p2_miss = 1'b0; tick(2);
        p1_miss = 1'b1; tick(2); p1_miss = 1'b0; tick(2);
        send(8'h41);
        tick(2);

        start_game(1'b1);                 // restart from GAME_OVER, miss in SERVE ignored
        score_miss(1'b1, 1'b0, 2, 1'b1);
        score_miss(1'b1, 1'b0, 2, 1'b1);
        score_miss(1'b1, 1'b0, 2, 1'b1);  // 0:3, P2 wins
        start_game(1'b0);
        score_miss(1'b0, 1'b1, 2, 1'b1);  // 1:0 and RUNNING
        tick(3);
        clear_to_idle(1'b1);              // rst mid-rally
        tick(3);

        end_req = 1'b1;
        tick(3);
        if (!end_done) begin
            failures++;
            $display("FAIL end_check got=not run required=run");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pong_game_ctl.md
Name: pong_game_ctl

Overview:
- Game-flow controller between UART_RX (and the debounced switches) and Pong_Top.
- Consumes UART receive bytes and ball-miss events from the ball logic; tracks both players' scores.
- Gates the ball with a serve delay and declares a winner.
- Produces the game-active enable and score values consumed by Pong_Top and its score renderer.

Parameters:
- CLKS_PER_SERVE, 12500000, serve pause in clk_i cycles (0.5 s at 25 MHz); minimum value 1.
- SCORE_LIMIT, 9, points needed to win; range 1..15.
- CMD_START, 8'h53, UART byte ('S') that starts or restarts play.
- CMD_RESET, 8'h52, UART byte ('R') that clears scores and returns to IDLE.

Ports:
- clk_i  in  1  system clock, 25 MHz
- rst_i  in  1  synchronous reset, active-high
- rx_dv_i  in  1  one-cycle byte-valid strobe from UART_RX
- rx_byte_i  in  8  received byte, valid when rx_dv_i=1
- p1_miss_i  in  1  level, high while ball is past the P1 (left) goal line
- p2_miss_i  in  1  level, high while ball is past the P2 (right) goal line
- game_active_o  out  1  ball motion enable; high only in RUNNING
- ball_reset_o  out  1  one-cycle pulse: re-centre the ball
- p1_score_o  out  4  player 1 score
- p2_score_o  out  4  player 2 score
- winner_o  out  2  00 none, 01 P1, 10 P2
- state_o  out  3  encoded FSM state, for debug/LED

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - state IDLE
  - game_active_o=0, ball_reset_o=0
  - both scores 0, winner_o=00
  - serve counter 0
  - miss edge registers 0
- Miss detection: rising-edge detect on each miss input using a registered previous value. A level held high scores once only.
- States:
  - IDLE(0): wait for a command.
    - rx_dv_i=1 with rx_byte_i=CMD_START -> pulse ball_reset_o, clear counter, go to SERVE.
    - All other bytes are ignored.
  - SERVE(1): count clk_i cycles.
    - When counter=CLKS_PER_SERVE-1 -> go to RUNNING and assert game_active_o from the next cycle.
    - Miss edges in this state are ignored.
  - RUNNING(2): game_active_o=1.
    - p1_miss edge -> p2_score+1.
    - p2_miss edge -> p1_score+1.
    - Either case -> go to POINT.
    - Both edges in the same cycle -> no score change, go to POINT.
  - POINT(3): one cycle, game_active_o=0.
    - If either score equals SCORE_LIMIT -> set winner_o, go to GAME_OVER.
    - Otherwise pulse ball_reset_o, clear counter, go to SERVE.
  - GAME_OVER(4): scores and winner_o hold.
    - CMD_START -> clear scores and winner_o, pulse ball_reset_o, go to SERVE.
- CMD_RESET in any state (highest priority below rst_i) -> clear scores, winner_o and counter; state IDLE; game_active_o=0.
- Unrecognised bytes are ignored in every state. CMD_START in SERVE or RUNNING is ignored.
- Scores:
  - Saturate at SCORE_LIMIT; never wrap.
  - The score increment is visible on the cycle after the miss edge, when the FSM is in POINT.
- Latency:
  - Miss edge to game_active_o low: 1 cycle.
  - CMD_START to game_active_o high: CLKS_PER_SERVE+1 cycles.
- Reset mid-serve or mid-rally returns to IDLE with all reset values within one cycle.
- Unused state encodings (5-7) recover to IDLE.
- Serve counter width: $clog2(CLKS_PER_SERVE+1).

Decomposition:
- Shared package pong_pkg:
  - state enum (IDLE..GAME_OVER)
  - winner encoding constants
  - CMD_START and CMD_RESET defaults
- One natural sub-module: pong_edge_detect, instantiated twice (one per miss input): registered rising-edge pulse with synchronous reset.

Test Plan:
1. Reset, then send CMD_START with CLKS_PER_SERVE=8 -> ball_reset_o pulses once; game_active_o rises exactly 9 cycles after rx_dv_i.
2. In RUNNING, hold p1_miss_i high for 20 cycles -> p2_score_o=1 exactly once; state passes through POINT then SERVE; ball_reset_o pulses once.
3. SCORE_LIMIT=3, three p2_miss edges -> p1_score_o=3, winner_o=01, state GAME_OVER. Further miss edges leave the scores at 3.
4. p1_miss_i and p2_miss_i rise in the same cycle -> both scores unchanged; FSM returns to SERVE.
5. Send CMD_RESET mid-SERVE with score 2:1 -> scores 0:0, state IDLE, game_active_o=0. A byte 0x41 then has no effect.
6. Assert rst_i during RUNNING -> next cycle all outputs at reset values. CMD_START in GAME_OVER restarts with scores 0:0.
